// File: rtl/alu_seq_if.sv
// alu_seq_if: groups the upstream (operation) and downstream (result)
// handshakes of the sequential ALU.
//   master : producer/consumer side (decoder + writeback, or a testbench)
//   slave  : the ALU itself
// Signals:
//   in_valid/in_ready  operation handshake, in0/in1/op operands and opcode
//   out_valid/out_ready result handshake, out result word
//   zf/cf/err          sticky zero, carry/borrow, illegal-operation flags
//   busy               ALU is rotating or holding a result
interface alu_seq_if #(
    parameter int WIDTH = 8,
    parameter int OP_W  = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [OP_W-1:0]  op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zf;
    logic             cf;
    logic             err;
    logic             busy;

    modport master (
        output in_valid, in0, in1, op, out_ready,
        input  in_ready, out_valid, out, zf, cf, err, busy
    );

    modport slave (
        input  in_valid, in0, in1, op, out_ready,
        output in_ready, out_valid, out, zf, cf, err, busy
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked multi-cycle ALU with sticky flags and iterative
// cube-orientation rotation (one quarter-turn per cycle).
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; discards any in-flight operation
//   bus  alu_seq_if.slave: operation in (in_valid/in_ready/in0/in1/op),
//        result out (out_valid/out_ready/out), flags zf/cf/err, busy
// Flow: IDLE accepts; plain ops finish on the accept edge (DONE next cycle);
// ROT ops spend one cycle per quarter-turn in ROT; DONE holds the result
// until out_ready.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int OP_W  = 5
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ROT  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [OP_W-1:0] OP_PASS  = OP_W'(5'h00);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(5'h01);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(5'h02);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(5'h03);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(5'h04);
    localparam logic [OP_W-1:0] OP_INC   = OP_W'(5'h05);
    localparam logic [OP_W-1:0] OP_DEC   = OP_W'(5'h06);
    localparam logic [OP_W-1:0] OP_CHECK = OP_W'(5'h07);
    localparam logic [OP_W-1:0] OP_ROTX  = OP_W'(5'h08);
    localparam logic [OP_W-1:0] OP_ROTZ  = OP_W'(5'h09);
    localparam logic [OP_W-1:0] OP_ROTY  = OP_W'(5'h0A);

    // Axis codes reuse op[1:0] of the ROT opcodes: X=00, Z=01, Y=10.
    localparam logic [1:0] AX_X = 2'd0;
    localparam logic [1:0] AX_Z = 2'd1;
    localparam logic [1:0] AX_Y = 2'd2;

    // One quarter-turn of an orientation code about the given axis.
    // Codes: 000 +y, 001 +x, 010 +z, 011 -x, 100 -z, 101 -y.
    function automatic logic [2:0] rot_once(input logic [2:0] o, input logic [1:0] axis);
        logic [2:0] r;
        r = o;
        case (axis)
            AX_X: begin
                case (o)
                    3'b000:  r = 3'b010;  // +y -> +z
                    3'b010:  r = 3'b101;  // +z -> -y
                    3'b101:  r = 3'b100;  // -y -> -z
                    3'b100:  r = 3'b000;  // -z -> +y
                    default: r = o;
                endcase
            end
            AX_Z: begin
                case (o)
                    3'b000:  r = 3'b001;  // +y -> +x
                    3'b001:  r = 3'b101;  // +x -> -y
                    3'b101:  r = 3'b011;  // -y -> -x
                    3'b011:  r = 3'b000;  // -x -> +y
                    default: r = o;
                endcase
            end
            AX_Y: begin
                case (o)
                    3'b001:  r = 3'b100;  // +x -> -z
                    3'b100:  r = 3'b011;  // -z -> -x
                    3'b011:  r = 3'b010;  // -x -> +z
                    3'b010:  r = 3'b001;  // +z -> +x
                    default: r = o;
                endcase
            end
            default: r = o;
        endcase
        return r;
    endfunction

    logic [1:0]       state_r, state_nx_s;
    logic [WIDTH-1:0] work_r, work_nx_s;
    logic [1:0]       turns_r, turns_nx_s;
    logic [1:0]       axis_r, axis_nx_s;
    logic [WIDTH-1:0] out_r, out_nx_s;
    logic             zf_r, zf_nx_s;
    logic             cf_r, cf_nx_s;
    logic             err_r, err_nx_s;
    logic             in_ready_r, out_valid_r, busy_r;

    logic [WIDTH-1:0] alu_res_s;
    logic             alu_zf_s, alu_cf_s, alu_err_s;
    logic [WIDTH:0]   sum_s, dif_s, inc_s, dec_s;
    logic             is_rot_s, orient_ok_s;
    logic [WIDTH-1:0] rotated_s;

    // Single-cycle ALU result and flag candidates for non-rotation opcodes.
    always_comb begin
        sum_s     = {1'b0, bus.in0} + {1'b0, bus.in1};
        dif_s     = {1'b0, bus.in0} - {1'b0, bus.in1};
        inc_s     = {1'b0, bus.in0} + {{WIDTH{1'b0}}, 1'b1};
        dec_s     = {1'b0, bus.in0} - {{WIDTH{1'b0}}, 1'b1};
        alu_res_s = bus.in0;
        alu_zf_s  = zf_r;
        alu_cf_s  = cf_r;
        alu_err_s = 1'b0;
        case (bus.op)
            OP_PASS:  alu_res_s = bus.in0;
            OP_AND:   alu_res_s = bus.in0 & bus.in1;
            OP_OR:    alu_res_s = bus.in0 | bus.in1;
            OP_ADD:   begin alu_res_s = sum_s[WIDTH-1:0]; alu_cf_s = sum_s[WIDTH]; end
            OP_SUB:   begin alu_res_s = dif_s[WIDTH-1:0]; alu_cf_s = dif_s[WIDTH]; end
            OP_INC:   begin alu_res_s = inc_s[WIDTH-1:0]; alu_cf_s = inc_s[WIDTH]; end
            OP_DEC:   begin alu_res_s = dec_s[WIDTH-1:0]; alu_cf_s = dec_s[WIDTH]; end
            OP_CHECK: begin alu_res_s = bus.in0; alu_zf_s = (bus.in0 == bus.in1); end
            OP_ROTX, OP_ROTZ, OP_ROTY: alu_res_s = bus.in0;
            default:  alu_err_s = 1'b1;
        endcase
    end

    // Rotation decode and the work word after one more quarter-turn.
    always_comb begin
        is_rot_s    = (bus.op == OP_ROTX) || (bus.op == OP_ROTZ) || (bus.op == OP_ROTY);
        orient_ok_s = (bus.in0[2:0] < 3'd6);
        rotated_s   = {work_r[WIDTH-1:3], rot_once(work_r[2:0], axis_r)};
    end

    // Next-state logic for the FSM, work register, result and flags.
    always_comb begin
        state_nx_s = state_r;
        work_nx_s  = work_r;
        turns_nx_s = turns_r;
        axis_nx_s  = axis_r;
        out_nx_s   = out_r;
        zf_nx_s    = zf_r;
        cf_nx_s    = cf_r;
        err_nx_s   = err_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (is_rot_s) begin
                        axis_nx_s = bus.op[1:0];
                        work_nx_s = bus.in0;
                        if (!orient_ok_s) begin
                            // Illegal orientation: completes as a zero-turn op.
                            out_nx_s   = bus.in0;
                            err_nx_s   = 1'b1;
                            turns_nx_s = 2'd0;
                            state_nx_s = ST_DONE;
                        end else if (bus.in1[1:0] == 2'd0) begin
                            out_nx_s   = bus.in0;
                            err_nx_s   = 1'b0;
                            turns_nx_s = 2'd0;
                            state_nx_s = ST_DONE;
                        end else begin
                            turns_nx_s = bus.in1[1:0];
                            state_nx_s = ST_ROT;
                        end
                    end else begin
                        out_nx_s   = alu_res_s;
                        zf_nx_s    = alu_zf_s;
                        cf_nx_s    = alu_cf_s;
                        err_nx_s   = alu_err_s;
                        state_nx_s = ST_DONE;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ROT: begin
                work_nx_s  = rotated_s;
                turns_nx_s = turns_r - 2'd1;
                if (turns_r == 2'd1) begin
                    out_nx_s   = rotated_s;
                    err_nx_s   = 1'b0;
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_ROT;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State registers; handshake/status outputs are registered from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            work_r      <= {WIDTH{1'b0}};
            turns_r     <= 2'd0;
            axis_r      <= 2'd0;
            out_r       <= {WIDTH{1'b0}};
            zf_r        <= 1'b0;
            cf_r        <= 1'b0;
            err_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            work_r      <= work_nx_s;
            turns_r     <= turns_nx_s;
            axis_r      <= axis_nx_s;
            out_r       <= out_nx_s;
            zf_r        <= zf_nx_s;
            cf_r        <= cf_nx_s;
            err_r       <= err_nx_s;
            in_ready_r  <= (state_nx_s == ST_IDLE);
            out_valid_r <= (state_nx_s == ST_DONE);
            busy_r      <= (state_nx_s == ST_ROT) || (state_nx_s == ST_DONE);
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out       = out_r;
    assign bus.zf        = zf_r;
    assign bus.cf        = cf_r;
    assign bus.err       = err_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven directed test of alu_seq plus hand-written
// sequences for rotation busy time, result back-pressure and mid-rotation reset.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    alu_seq_if #(.WIDTH(8), .OP_W(5)) bus ();

    alu_seq #(.WIDTH(8), .OP_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       zf;
        logic       cf;
        logic       err;
        int         lat;
    } vec_t;

    vec_t vt[23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for in_ready, presents one op for one edge, waits for out_valid.
    task automatic run_op(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                          output int lat);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            step();
            n++;
        end
        chk("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
        bus.op = op;
        bus.in0 = a;
        bus.in1 = b;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int lat;
        bus.in_valid = 1'b0;
        bus.in0 = 8'h00;
        bus.in1 = 8'h00;
        bus.op = 5'h00;
        bus.out_ready = 1'b1;

        //          op     a      b      res    zf    cf    err   lat
        vt[0]  = '{5'h03, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1, 1'b0, 1};
        vt[1]  = '{5'h07, 8'h5A, 8'h5A, 8'h5A, 1'b1, 1'b1, 1'b0, 1};
        vt[2]  = '{5'h03, 8'h01, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1};
        vt[3]  = '{5'h07, 8'h01, 8'h02, 8'h01, 1'b0, 1'b0, 1'b0, 1};
        vt[4]  = '{5'h04, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b1, 1'b0, 1};
        vt[5]  = '{5'h06, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 1};
        vt[6]  = '{5'h05, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1};
        vt[7]  = '{5'h1F, 8'h5B, 8'h00, 8'h5B, 1'b0, 1'b1, 1'b1, 1};
        vt[8]  = '{5'h08, 8'h07, 8'h01, 8'h07, 1'b0, 1'b1, 1'b1, 1};
        vt[9]  = '{5'h05, 8'h41, 8'h00, 8'h42, 1'b0, 1'b0, 1'b0, 1};
        vt[10] = '{5'h01, 8'hCC, 8'hAA, 8'h88, 1'b0, 1'b0, 1'b0, 1};
        vt[11] = '{5'h02, 8'hC0, 8'h0A, 8'hCA, 1'b0, 1'b0, 1'b0, 1};
        vt[12] = '{5'h00, 8'h3C, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b0, 1};
        vt[13] = '{5'h07, 8'h77, 8'h77, 8'h77, 1'b1, 1'b0, 1'b0, 1};
        vt[14] = '{5'h08, 8'hA8, 8'h01, 8'hAA, 1'b1, 1'b0, 1'b0, 2};
        vt[15] = '{5'h08, 8'hA8, 8'h03, 8'hAC, 1'b1, 1'b0, 1'b0, 4};
        vt[16] = '{5'h09, 8'h01, 8'h02, 8'h03, 1'b1, 1'b0, 1'b0, 3};
        vt[17] = '{5'h0A, 8'h00, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 2};
        vt[18] = '{5'h0A, 8'h21, 8'h01, 8'h24, 1'b1, 1'b0, 1'b0, 2};
        vt[19] = '{5'h08, 8'h2A, 8'h00, 8'h2A, 1'b1, 1'b0, 1'b0, 1};
        vt[20] = '{5'h04, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 1};
        vt[21] = '{5'h06, 8'h10, 8'h00, 8'h0F, 1'b1, 1'b0, 1'b0, 1};
        vt[22] = '{5'h0B, 8'h99, 8'h00, 8'h99, 1'b1, 1'b0, 1'b1, 1};

        step();
        step();
        rst = 1'b0;
        step();
        chk("reset_out", {24'd0, bus.out}, 32'h0);
        chk("reset_flags", {28'd0, bus.out_valid, bus.zf, bus.cf, bus.err}, 32'h0);
        chk("reset_busy_ready", {30'd0, bus.busy, bus.in_ready}, 32'h1);

        for (int i = 0; i < 23; i++) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, lat);
            chk($sformatf("v%0d_out", i), {24'd0, bus.out}, {24'd0, vt[i].res});
            chk($sformatf("v%0d_zf_cf_err", i), {29'd0, bus.zf, bus.cf, bus.err},
                {29'd0, vt[i].zf, vt[i].cf, vt[i].err});
            chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
        end

        // ROT_X count 3 with the result back-pressured, plus an ignored offer.
        step();
        chk("rot3_start_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.out_ready = 1'b0;
        bus.op = 5'h08;
        bus.in0 = 8'hA8;
        bus.in1 = 8'h03;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rot3_busy_%0d", k), {29'd0, bus.busy, bus.out_valid, bus.in_ready},
                32'b100);
            step();
        end
        chk("rot3_done", {30'd0, bus.out_valid, bus.busy}, 32'b11);
        chk("rot3_out", {24'd0, bus.out}, 32'hAC);
        bus.op = 5'h03;
        bus.in0 = 8'h01;
        bus.in1 = 8'h01;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("stall_%0d", k), {22'd0, bus.out, bus.out_valid, bus.in_ready},
                {22'd0, 8'hAC, 1'b1, 1'b0});
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("release_idle", {22'd0, bus.out, bus.out_valid, bus.in_ready},
            {22'd0, 8'hAC, 1'b0, 1'b1});
        run_op(5'h00, 8'h66, 8'h00, lat);
        chk("after_stall_out", {24'd0, bus.out}, 32'h66);
        chk("after_stall_lat", lat, 1);

        // Reset after the first turn of a 3-turn rotation.
        step();
        bus.op = 5'h08;
        bus.in0 = 8'hA8;
        bus.in1 = 8'h03;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrot_reset_out", {24'd0, bus.out}, 32'h0);
        chk("midrot_reset_state", {27'd0, bus.out_valid, bus.busy, bus.zf, bus.cf, bus.err},
            32'h0);
        chk("midrot_reset_ready", {31'd0, bus.in_ready}, 32'd1);
        run_op(5'h03, 8'hF0, 8'h20, lat);
        chk("post_reset_add", {21'd0, bus.out, bus.zf, bus.cf, bus.err},
            {21'd0, 8'h10, 1'b0, 1'b1, 1'b0});
        chk("post_reset_lat", lat, 1);

        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
